// File: rtl/signed_subtractor_pipe_if.sv
// Stream bundle for signed_subtractor_pipe: operand beat in (a, b) with
// valid/ready, and result beat out (out, ovf) with valid/ready.
// master = producer of operands / consumer of results (testbench, upstream PE)
// slave  = the subtractor pipeline itself
interface signed_subtractor_pipe_if #(
    parameter int IN1_WIDTH = 20,
    parameter int IN2_WIDTH = 32,
    parameter int OUT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN1_WIDTH-1:0] a;
    logic [IN2_WIDTH-1:0] b;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out;
    logic                 ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, ovf
    );
endinterface

// File: rtl/signed_subtractor_pipe.sv
// Two-stage pipelined signed subtractor: out = a - b.
//   S1 registers sign-extended operands (W = max(IN1,IN2)+1 bits, so the
//   difference is exact); S2 registers the resized difference and an
//   overflow flag. Valid/ready stream with a global enable that freezes
//   every flop when low.
// Optional feature macro: SIGNED_SUB_SATURATE_EN
//   defined     -> out-of-range differences clamp to the OUT_WIDTH limits
//   not defined -> out-of-range differences wrap (low OUT_WIDTH bits)
//   In both builds ovf=1 marks an out-of-range beat.
module signed_subtractor_pipe #(
    parameter int IN1_WIDTH = 20,
    parameter int IN2_WIDTH = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,   // asynchronous, active-low
    input  logic                     enable,
    signed_subtractor_pipe_if.slave  bus
);
    localparam int W = ((IN1_WIDTH > IN2_WIDTH) ? IN1_WIDTH : IN2_WIDTH) + 1;

    // Pipeline state
    logic                 s1_valid_q, s1_valid_d;
    logic [W-1:0]         a_ext_q, a_ext_d;
    logic [W-1:0]         b_ext_q, b_ext_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic                 ovf_q, ovf_d;

    // Handshake and datapath nets
    logic                 s2_adv_s;
    logic                 consume_s;
    logic                 accept_s;
    logic                 in_ready_s;
    logic [W-1:0]         diff_s;
    logic [OUT_WIDTH-1:0] res_s;
    logic                 res_ovf_s;

`ifdef SIGNED_SUB_SATURATE_EN
    // Clamp value for an out-of-range difference, chosen by its sign.
    function automatic logic [OUT_WIDTH-1:0] sat_value(input logic neg);
        logic [OUT_WIDTH-1:0] v;
        if (neg) begin
            v = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            v = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
        return v;
    endfunction
`endif

    // Advance/accept/consume decisions; everything is gated by enable, and
    // in_ready is also held low while reset is asserted.
    always_comb begin
        s2_adv_s   = enable & s1_valid_q & (~out_valid_q | bus.out_ready);
        consume_s  = enable & out_valid_q & bus.out_ready;
        in_ready_s = reset & enable & (~s1_valid_q | s2_adv_s);
        accept_s   = bus.in_valid & in_ready_s;
    end

    // Exact W-bit difference of the registered operands.
    assign diff_s = a_ext_q - b_ext_q;

    generate
        if (OUT_WIDTH >= W) begin : g_wide
            // Result always fits: sign-extend, never overflows.
            always_comb begin
                res_s     = OUT_WIDTH'($signed(diff_s));
                res_ovf_s = 1'b0;
            end
        end else begin : g_narrow
            // Bits that must all equal the result sign for d to fit.
            logic [W-OUT_WIDTH:0] top_s;
            assign top_s = diff_s[W-1:OUT_WIDTH-1];

            // Range check, then wrap or clamp the narrowed result.
            always_comb begin
                res_ovf_s = ~((&top_s) | ~(|top_s));
`ifdef SIGNED_SUB_SATURATE_EN
                if (res_ovf_s) begin
                    res_s = sat_value(diff_s[W-1]);
                end else begin
                    res_s = diff_s[OUT_WIDTH-1:0];
                end
`else
                res_s = diff_s[OUT_WIDTH-1:0];
`endif
            end
        end
    endgenerate

    // Next-state for both stages: S1 loads on accept and empties on advance;
    // the output stage loads on advance and empties on a bare consume.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        a_ext_d     = a_ext_q;
        b_ext_d     = b_ext_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ovf_d       = ovf_q;

        if (accept_s) begin
            s1_valid_d = 1'b1;
            a_ext_d    = W'($signed(bus.a));
            b_ext_d    = W'($signed(bus.b));
        end else if (s2_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_adv_s) begin
            out_valid_d = 1'b1;
            out_d       = res_s;
            ovf_d       = res_ovf_s;
        end else if (consume_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; reset discards every in-flight beat at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            a_ext_q     <= {W{1'b0}};
            b_ext_q     <= {W{1'b0}};
            out_valid_q <= 1'b0;
            out_q       <= {OUT_WIDTH{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_ext_q     <= a_ext_d;
            b_ext_q     <= b_ext_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_signed_subtractor_pipe.sv
// Scoreboard bench for signed_subtractor_pipe (default widths 20/32/32).
// The driver pushes the model's expected result when a beat is accepted;
// an independent monitor pops and compares whenever a result is consumed.
module tb_signed_subtractor_pipe;
    localparam int IN1_W = 20;
    localparam int IN2_W = 32;
    localparam int OUT_W = 32;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic ready_ctl;
    logic rand_mode;
    logic rand_bit;

    always #5 clk = ~clk;

    signed_subtractor_pipe_if #(.IN1_WIDTH(IN1_W), .IN2_WIDTH(IN2_W), .OUT_WIDTH(OUT_W)) bus ();

    assign bus.out_ready = ready_ctl & (~rand_mode | rand_bit);

    signed_subtractor_pipe #(.IN1_WIDTH(IN1_W), .IN2_WIDTH(IN2_W), .OUT_WIDTH(OUT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] o;
        logic        v;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_push = 0;
    int   n_pop  = 0;
    bit   bp_done;
    bit   st_done;
    int   base_push;
    int   base_pop;
    logic [31:0] sv_out;
    logic        sv_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer difference, then range test against 32-bit signed.
    function automatic void model(input logic [19:0] av, input logic [31:0] bv,
                                  output logic [31:0] o, output logic v);
        longint sa, sb, d;
        longint max_v, min_v;
        sa    = longint'($signed(av));
        sb    = longint'($signed(bv));
        d     = sa - sb;
        max_v = 64'sd2147483647;
        min_v = -64'sd2147483648;
        v     = (d > max_v) || (d < min_v);
`ifdef SIGNED_SUB_SATURATE_EN
        if (d > max_v)      o = 32'h7FFFFFFF;
        else if (d < min_v) o = 32'h80000000;
        else                o = d[31:0];
`else
        o = d[31:0];
`endif
    endfunction

    // Offer one beat starting now (just after a rising edge); returns just after the accept edge.
    task automatic send(input logic [19:0] av, input logic [31:0] bv);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready && enable) ok = 1'b1;
        end
        if (ok) begin
            model(av, bv, e.o, e.v);
            sb_q.push_back(e);
            n_push++;
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: beat a=%0h b=%0h not accepted within 100 cycles", av, bv);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Single beat on an empty pipe with out_ready=1: result visible exactly 2 edges after offer.
    task automatic send_expect(input string name, input logic [19:0] av, input logic [31:0] bv,
                               input logic [31:0] eo, input logic ev);
        send(av, bv);
        chk({name, "_lat1_valid"}, 64'(bus.out_valid), 64'(1'b0));
        @(posedge clk);
        #1;
        chk({name, "_lat2_valid"}, 64'(bus.out_valid), 64'(1'b1));
        chk({name, "_out"}, 64'(bus.out), 64'(eo));
        chk({name, "_ovf"}, 64'(bus.ovf), 64'(ev));
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb_q.size()), 64'(0));
    endtask

    always @(posedge clk) rand_bit <= ($urandom_range(0, 3) != 0);

    // Monitor: every consumed result must match the oldest expected one.
    always @(negedge clk) begin
        if (reset && enable && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %0h expected no output", bus.out);
            end else begin
                mon_e = sb_q.pop_front();
                n_pop++;
                chk("sb_out", 64'(bus.out), 64'(mon_e.o));
                chk("sb_ovf", 64'(bus.ovf), 64'(mon_e.v));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] ra;
        logic [31:0] rb;
        reset        = 1'b0;
        enable       = 1'b1;
        ready_ctl    = 1'b1;
        rand_mode    = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 20'h00000;
        bus.b        = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1'b0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
        chk("rst_out",       64'(bus.out),       64'(32'h0));
        chk("rst_ovf",       64'(bus.ovf),       64'(1'b0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        send_expect("v_basic", 20'h01234, 32'h00000001, 32'h00001233, 1'b0);
        send_expect("v_neg1",  20'h00000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        send_expect("v_zero",  20'hFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
`ifdef SIGNED_SUB_SATURATE_EN
        send_expect("v_ovf_lo", 20'h80000, 32'h7FFFFFFF, 32'h80000000, 1'b1);
        send_expect("v_ovf_hi", 20'h7FFFF, 32'h80000000, 32'h7FFFFFFF, 1'b1);
`else
        send_expect("v_ovf_lo", 20'h80000, 32'h7FFFFFFF, 32'h7FF80001, 1'b1);
        send_expect("v_ovf_hi", 20'h7FFFF, 32'h80000000, 32'h8007FFFF, 1'b1);
`endif
        drain();

        // Back-pressure: 4 beats offered, only 2 fit while out_ready=0
        ready_ctl = 1'b0;
        bp_done   = 1'b0;
        base_push = n_push;
        base_pop  = n_pop;
        fork
            begin
                for (int i = 0; i < 4; i++) send(20'(i * 3 + 5), 32'(i));
                bp_done = 1'b1;
            end
        join_none
        repeat (6) @(posedge clk);
        #1;
        chk("bp_accepted",  64'(n_push - base_push), 64'(2));
        chk("bp_in_ready",  64'(bus.in_ready),       64'(1'b0));
        chk("bp_out_valid", 64'(bus.out_valid),      64'(1'b1));
        ready_ctl = 1'b1;
        for (int k = 0; k < 60 && !bp_done; k++) @(posedge clk);
        chk("bp_done", 64'(bp_done), 64'(1'b1));
        drain();
        chk("bp_results", 64'(n_pop - base_pop), 64'(4));

        // Random stream with random downstream stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 20'h80000;
                1:       ra = 20'h7FFFF;
                default: ra = 20'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       rb = 32'h80000000;
                1:       rb = 32'h7FFFFFFF;
                default: rb = $urandom;
            endcase
            send(ra, rb);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rand_mode = 1'b0;

        // Enable freeze in the middle of a running stream
        st_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) send(20'($urandom), $urandom);
                st_done = 1'b1;
            end
        join_none
        repeat (4) @(posedge clk);
        #1;
        enable   = 1'b0;
        sv_out   = bus.out;
        sv_valid = bus.out_valid;
        chk("frz_had_valid", 64'(sv_valid), 64'(1'b1));
        repeat (3) begin
            @(negedge clk);
            chk("frz_out",      64'(bus.out),       64'(sv_out));
            chk("frz_valid",    64'(bus.out_valid), 64'(sv_valid));
            chk("frz_in_ready", 64'(bus.in_ready),  64'(1'b0));
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        for (int k = 0; k < 100 && !st_done; k++) @(posedge clk);
        chk("frz_done", 64'(st_done), 64'(1'b1));
        drain();

        // Reset with two beats in flight
        ready_ctl = 1'b0;
        send(20'h00100, 32'h00000002);
        send(20'h00200, 32'h00000003);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
        chk("mid_rst_out",       64'(bus.out),       64'(32'h0));
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'(1'b0));
        n_push = n_push - sb_q.size();
        sb_q.delete();
        ready_ctl = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_expect("post_rst", 20'h00010, 32'h00000003, 32'h0000000D, 1'b0);
        drain();
        chk("push_pop_balance", 64'(n_pop), 64'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
